lab7_soc_aes_start_pio: RTL and testbench

//  Avalon-MM slave output PIO driving the AES core's control bits (START and mode bits) from the Nios II.

---
 rtl/lab7_soc_pio_pkg.sv | 14 +
 rtl/lab7_soc_sync_edge.sv | 27 ++
 rtl/lab7_soc_aes_start_pio.sv | 101 ++++++++++
 tb/tb_lab7_soc_aes_start_pio.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab7_soc_pio_pkg.sv
// Shared definitions for the lab7_soc PIO blocks: register offsets and STATUS bit positions.
package lab7_soc_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA     = 2'd0,
        ADDR_STATUS   = 2'd1,
        ADDR_OUTSET   = 2'd2,
        ADDR_OUTCLEAR = 2'd3
    } pio_addr_e;

    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_DONE_SEEN = 1;

endpackage

// File: rtl/lab7_soc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module lab7_soc_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/lab7_soc_aes_start_pio.sv
// Avalon-MM output PIO for the AES control bits: set/clear aliases, START strobe,
// and hardware auto-clear of START on the core's done rising edge.
module lab7_soc_aes_start_pio
    import lab7_soc_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned START_BIT   = 0,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic             done_in,
    output logic [WIDTH-1:0] out_port,
    output logic             start_pulse
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             done_seen_q, done_seen_d;
    logic             start_pulse_q, start_pulse_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr;
    logic             done_rise;
    logic [WIDTH-1:0] wd;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_unused_wd
        logic unused_wd_hi;
        assign unused_wd_hi = |writedata[31:WIDTH];
    end

    lab7_soc_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_done_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .async_i(done_in),
        .rise_o (done_rise)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        data_d      = data_q;
        done_seen_d = done_seen_q;

        if (done_rise) begin
            data_d[START_BIT] = 1'b0;
        end

        // A software write replaces the auto-cleared value, so a restart beats a concurrent done.
        if (wr) begin
            unique case (address)
                ADDR_DATA:     data_d      = wd;
                ADDR_OUTSET:   data_d      = data_q | wd;
                ADDR_OUTCLEAR: data_d      = data_q & ~wd;
                ADDR_STATUS:   done_seen_d = 1'b0;
                default:       data_d      = data_q;
            endcase
        end

        if (done_rise) begin
            done_seen_d = 1'b1;
        end

        start_pulse_d = data_d[START_BIT] & ~data_q[START_BIT];

        readdata_d = '0;
        if (address == ADDR_STATUS) begin
            readdata_d[ST_BUSY]      = data_q[START_BIT];
            readdata_d[ST_DONE_SEEN] = done_seen_q;
        end else begin
            readdata_d[WIDTH-1:0] = data_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q        <= RESET_VALUE[WIDTH-1:0];
            done_seen_q   <= 1'b0;
            start_pulse_q <= 1'b0;
            readdata_q    <= '0;
        end else begin
            data_q        <= data_d;
            done_seen_q   <= done_seen_d;
            start_pulse_q <= start_pulse_d;
            readdata_q    <= readdata_d;
        end
    end

    assign out_port    = data_q;
    assign start_pulse = start_pulse_q;
    assign readdata    = readdata_q;

endmodule

// File: tb/tb_lab7_soc_aes_start_pio.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a behavioural register model.
module tb_lab7_soc_aes_start_pio;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned START_BIT   = 0;
    localparam logic [31:0] RESET_VALUE = 32'h0;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [31:0] MASK        = (WIDTH == 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic             done_in;
    logic [WIDTH-1:0] out_port;
    logic             start_pulse;

    int n_checks = 0;
    int n_err    = 0;

    lab7_soc_aes_start_pio #(
        .WIDTH      (WIDTH),
        .START_BIT  (START_BIT),
        .RESET_VALUE(RESET_VALUE),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .done_in    (done_in),
        .out_port   (out_port),
        .start_pulse(start_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registers as plain integers, done history as a sample delay line.
    logic [31:0]          m_data;
    logic                 m_seen;
    logic                 m_pulse;
    logic [31:0]          m_rd;
    logic [SYNC_STAGES:0] m_hist;

    initial begin
        logic        rise;
        logic [31:0] nd;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_data  = RESET_VALUE & MASK;
                m_seen  = 1'b0;
                m_pulse = 1'b0;
                m_rd    = 32'h0;
                m_hist  = '0;
            end else begin
                // done sampled SYNC_STAGES edges ago is high and the one before it was low
                rise = m_hist[SYNC_STAGES-1] && !m_hist[SYNC_STAGES];
                m_rd = (address == 2'd1) ? {30'h0, m_seen, m_data[START_BIT]} : m_data;
                nd   = m_data;
                if (rise) nd[START_BIT] = 1'b0;
                if (chipselect && !write_n) begin
                    if (address == 2'd0) nd = writedata & MASK;
                    if (address == 2'd2) nd = (m_data | writedata) & MASK;
                    if (address == 2'd3) nd = m_data & ~writedata & MASK;
                    if (address == 2'd1) m_seen = 1'b0;
                end
                if (rise) m_seen = 1'b1;
                m_pulse = nd[START_BIT] && !m_data[START_BIT];
                m_data  = nd;
                m_hist  = {m_hist[SYNC_STAGES-1:0], done_in};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reset_n) begin
                check("model_out_port", {{(32-WIDTH){1'b0}}, out_port}, m_data);
                check("model_readdata", readdata, m_rd);
                check("model_start_pulse", {31'h0, start_pulse}, {31'h0, m_pulse});
            end
        end
    end

    // Callers are positioned at a negedge; returns one negedge later.
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        done_in    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_port", {24'h0, out_port}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;

        // 1: reset asserted in the middle of a write
        wr_reg(2'd0, 32'hA5);
        check("t1_out_a5", {24'h0, out_port}, 32'hA5);
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h5A;
        #2 reset_n = 1'b0;
        #1;
        check("t1_rst_out_port", {24'h0, out_port}, 32'h0);
        check("t1_rst_readdata", readdata, 32'h0);
        check("t1_rst_pulse", {31'h0, start_pulse}, 32'h0);
        @(negedge clk);
        check("t1_rst_hold_out", {24'h0, out_port}, 32'h0);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b1;

        // 2: start via DATA write
        wr_reg(2'd0, 32'h01);
        check("t2_out", {24'h0, out_port}, 32'h01);
        check("t2_pulse_hi", {31'h0, start_pulse}, 32'h1);
        rd_reg(2'd1);
        check("t2_pulse_lo", {31'h0, start_pulse}, 32'h0);
        check("t2_status", readdata, 32'h1);

        // 3: set/clear aliases
        wr_reg(2'd0, 32'h00);
        wr_reg(2'd2, 32'h81);
        check("t3_set_out", {24'h0, out_port}, 32'h81);
        check("t3_set_pulse", {31'h0, start_pulse}, 32'h1);
        wr_reg(2'd3, 32'h80);
        check("t3_clr_out", {24'h0, out_port}, 32'h01);
        check("t3_clr_pulse", {31'h0, start_pulse}, 32'h0);

        // 4: done rise auto-clears START after SYNC_STAGES+1 edges
        done_in = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_before_clear", {24'h0, out_port}, 32'h01);
        @(negedge clk);
        check("t4_cleared", {24'h0, out_port}, 32'h00);
        rd_reg(2'd1);
        check("t4_status_seen", readdata, 32'h2);
        wr_reg(2'd1, 32'h1234);
        rd_reg(2'd1);
        check("t4_status_cleared", readdata, 32'h0);
        wr_reg(2'd0, 32'h01);
        repeat (4) @(negedge clk);
        check("t4_no_reclear", {24'h0, out_port}, 32'h01);
        done_in = 1'b0;
        wr_reg(2'd3, 32'h01);
        repeat (4) @(negedge clk);

        // 5: restart write in the same cycle as the synchronized done rise
        done_in = 1'b1;
        repeat (2) @(negedge clk);
        wr_reg(2'd0, 32'h01);
        check("t5_out", {24'h0, out_port}, 32'h01);
        check("t5_pulse", {31'h0, start_pulse}, 32'h1);
        rd_reg(2'd1);
        check("t5_status", readdata, 32'h3);

        // 6: upper write bits ignored, zero-extended read
        wr_reg(2'd0, 32'hFFFF_FFFF);
        check("t6_out", {24'h0, out_port}, 32'hFF);
        rd_reg(2'd0);
        check("t6_read", readdata, 32'h0000_00FF);

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 800; i++) begin
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = $urandom_range(0, 1);
            address    = 2'($urandom_range(0, 3));
            writedata  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) done_in = ~done_in;
            if (i == 400) begin
                #3 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
